bus_handshakes_rr_arbiter: RTL and testbench

//   N:1 round-robin arbiter sharing one valid/ready channel between NUM_SRC sources.

---
 rtl/bus_handshakes_rr_arbiter_pkg.sv | 23 ++
 rtl/bus_handshakes_rr_arbiter_if.sv | 39 +++
 rtl/bus_handshakes_rr_arbiter_pick.sv | 42 ++++
 rtl/bus_handshakes_rr_arbiter.sv | 119 +++++++++++
 tb/tb_bus_handshakes_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_handshakes_rr_arbiter_pkg.sv
// rtl/bus_handshakes_rr_arbiter_pkg.sv - shared types and helpers for the round-robin arbiter
//
// Contents:
//   state_e : arbiter FSM states (IDLE, BUSY)
//   clog2   : ceiling log2, usable in constant expressions for derived widths
package bus_handshakes_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Smallest r with 2**r >= n; bounded loop so it folds as a constant function.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_handshakes_rr_arbiter_if.sv
// rtl/bus_handshakes_rr_arbiter_if.sv - N:1 valid/ready bundle between sources, arbiter and sink
//
// Signals:
//   src_vaild [NUM_SRC]        per-source valid
//   src_data  [NUM_SRC*WIDTH]  packed source data, source i at [i*WIDTH +: WIDTH]
//   src_ready [NUM_SRC]        per-source ready
//   dst_vaild, dst_data, dst_id, dst_last, dst_ready : shared downstream channel
// Modports:
//   slave  : arbiter view (consumes sources, drives the shared channel)
//   master : environment view (drives sources and downstream ready)
interface bus_handshakes_rr_arbiter_if
  import bus_handshakes_pkg::*;
#(
  parameter int WIDTH   = 9,
  parameter int NUM_SRC = 4
) ();

  localparam int ID_W = clog2(NUM_SRC);

  logic [NUM_SRC-1:0]       src_vaild;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_ready;
  logic                     dst_vaild;
  logic [WIDTH-1:0]         dst_data;
  logic [ID_W-1:0]          dst_id;
  logic                     dst_last;
  logic                     dst_ready;

  modport slave (
    input  src_vaild, src_data, dst_ready,
    output src_ready, dst_vaild, dst_data, dst_id, dst_last
  );

  modport master (
    output src_vaild, src_data, dst_ready,
    input  src_ready, dst_vaild, dst_data, dst_id, dst_last
  );

endinterface

// File: rtl/bus_handshakes_rr_arbiter_pick.sv
// rtl/bus_handshakes_rr_arbiter_pick.sv - combinational round-robin priority pick
//
// Ports:
//   req_i [NUM_SRC]  request vector
//   ptr_i [ID_W]     index searched first (must be < NUM_SRC)
//   any_o            at least one request present
//   idx_o [ID_W]     first requester at or after ptr_i, wrapping mod NUM_SRC
module rr_priority_pick
  import bus_handshakes_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]        req_i,
  input  logic [clog2(NUM_SRC)-1:0] ptr_i,
  output logic                      any_o,
  output logic [clog2(NUM_SRC)-1:0] idx_o
);

  localparam int ID_W = clog2(NUM_SRC);
  localparam logic [ID_W:0] NUM_W = (ID_W + 1)'(NUM_SRC);

  logic [NUM_SRC-1:0] req_rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  always_comb begin
    // Rotating the doubled vector keeps the wrap exact for any NUM_SRC,
    // not just powers of two: bit k of req_rot is req[(ptr+k) mod NUM_SRC].
    req_rot = NUM_SRC'({req_i, req_i} >> ptr_i);
    off = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) off = ID_W'(k);
    end
    // Rotate back; ptr+off < 2*NUM_SRC so one conditional subtract suffices.
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= NUM_W) sum = sum - NUM_W;
    idx_o = sum[ID_W-1:0];
  end

  assign any_o = |req_i;

endmodule

// File: rtl/bus_handshakes_rr_arbiter.sv
// rtl/bus_handshakes_rr_arbiter.sv - N:1 round-robin burst arbiter on a valid/ready channel
//
// Ports:
//   clk_i    rising-edge clock
//   s_rst_i  synchronous reset, active-high
//   start_i  arbitration enable; low blocks new grants, a running grant finishes
//   bus      slave modport of bus_handshakes_rr_arbiter_if (sources + shared channel)
// A grant costs one IDLE arbitration cycle, then the granted source passes
// straight through for up to BURST beats before the pointer rotates.
module bus_handshakes_rr_arbiter
  import bus_handshakes_pkg::*;
#(
  parameter int WIDTH   = 9,
  parameter int NUM_SRC = 4,
  parameter int BURST   = 16
) (
  input  logic                       clk_i,
  input  logic                       s_rst_i,
  input  logic                       start_i,
  bus_handshakes_rr_arbiter_if.slave bus
);

  localparam int ID_W  = clog2(NUM_SRC);
  localparam int CNT_W = clog2(BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_SRC - 1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;
  logic             sel_vaild;
  logic [WIDTH-1:0] sel_data;

  rr_priority_pick #(
    .NUM_SRC(NUM_SRC)
  ) u_pick (
    .req_i(bus.src_vaild),
    .ptr_i(ptr_q),
    .any_o(pick_any),
    .idx_o(pick_idx)
  );

  // Constant-index mux avoids out-of-range dynamic selects for odd NUM_SRC.
  always_comb begin
    sel_vaild = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_q == ID_W'(i)) begin
        sel_vaild = bus.src_vaild[i];
        sel_data  = bus.src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    bus.src_ready = '0;
    bus.dst_vaild = 1'b0;
    bus.dst_data  = '0;
    bus.dst_id    = '0;
    bus.dst_last  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && pick_any) begin
          gnt_d   = pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        // Outputs are masked during reset so an aborted grant cannot
        // complete a handshake on the reset edge.
        if (!s_rst_i) begin
          bus.dst_vaild = sel_vaild;
          bus.dst_data  = sel_data;
          bus.dst_id    = gnt_q;
          bus.dst_last  = sel_vaild && (cnt_q == LAST_CNT);
          for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_q == ID_W'(i)) bus.src_ready[i] = bus.dst_ready;
          end
        end

        if (!sel_vaild || (bus.dst_ready && cnt_q == LAST_CNT)) begin
          state_d = IDLE;
          cnt_d   = '0;
          ptr_d   = (gnt_q == LAST_ID) ? '0 : gnt_q + ID_W'(1);
        end else if (bus.dst_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_handshakes_rr_arbiter.sv
// tb/tb_bus_handshakes_rr_arbiter.sv - directed bench for the round-robin burst arbiter
module tb_bus_handshakes_rr_arbiter;

  localparam int WIDTH   = 9;
  localparam int NUM_SRC = 4;
  localparam int BURST   = 16;

  logic clk = 1'b0;
  logic s_rst;
  logic start;

  bus_handshakes_rr_arbiter_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC)) bus ();

  bus_handshakes_rr_arbiter #(
    .WIDTH(WIDTH),
    .NUM_SRC(NUM_SRC),
    .BURST(BURST)
  ) dut (
    .clk_i(clk),
    .s_rst_i(s_rst),
    .start_i(start),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic       st;
    logic [3:0] v;
    logic       rdy;
    logic [3:0] e_srdy;
    logic       e_dv;
    logic [1:0] e_id;
    logic       e_last;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic [3:0] v,
                              input logic rdy, input logic [3:0] e_srdy, input logic e_dv,
                              input logic [1:0] e_id, input logic e_last);
    vec_t r;
    r.rst = rst; r.st = st; r.v = v; r.rdy = rdy;
    r.e_srdy = e_srdy; r.e_dv = e_dv; r.e_id = e_id; r.e_last = e_last;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] word(input int i);
    return WIDTH'(9'h0A0 + 9'(i * 17));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_data();
    for (int i = 0; i < NUM_SRC; i++) bus.src_data[i*WIDTH +: WIDTH] = word(i);
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    start = 1'b0;
    bus.src_vaild = '0;
    bus.dst_ready = 1'b1;
    tick();
    tick();
    s_rst = 1'b0;
  endtask

  task automatic check_idle(input string name);
    #2;
    check({name, ".dv"}, 32'(bus.dst_vaild), 32'd0);
    check({name, ".srdy"}, 32'(bus.src_ready), 32'd0);
  endtask

  initial begin
    s_rst = 1'b1;
    start = 1'b0;
    bus.src_vaild = '0;
    bus.dst_ready = 1'b0;
    set_all_data();
    tick();

    // rst st  v       rdy  srdy    dv  id  last
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 1, 4'b1111, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0000, 0, 0, 0));   // arbitrate -> src0
    tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0001, 0, 0, 0));   // src0 idle -> release, ptr=1
    tbl.push_back(mk(0, 1, 4'b0100, 1, 4'b0000, 0, 0, 0));   // -> src2
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 4'b0100, 1, 4'b0100, 1, 2, 0));
    tbl.push_back(mk(0, 1, 4'b0001, 1, 4'b0100, 0, 2, 0));   // early release, ptr=3
    tbl.push_back(mk(0, 1, 4'b0001, 1, 4'b0000, 0, 0, 0));   // search 3,0 -> src0
    tbl.push_back(mk(0, 1, 4'b0001, 1, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0001, 0, 0, 0));   // release, ptr=1
    tbl.push_back(mk(0, 0, 4'b1001, 1, 4'b0000, 0, 0, 0));   // start low: no grant
    tbl.push_back(mk(0, 1, 4'b1001, 1, 4'b0000, 0, 0, 0));   // search 1,2,3 -> src3
    tbl.push_back(mk(0, 1, 4'b1001, 0, 4'b0000, 1, 3, 0));   // held by dst_ready=0
    tbl.push_back(mk(0, 1, 4'b1001, 1, 4'b1000, 1, 3, 0));
    tbl.push_back(mk(1, 1, 4'b0011, 1, 4'b0000, 0, 0, 0));   // reset mid-burst
    tbl.push_back(mk(0, 1, 4'b0011, 1, 4'b0000, 0, 0, 0));   // ptr back to 0 -> src0
    tbl.push_back(mk(0, 1, 4'b0011, 1, 4'b0001, 1, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      s_rst = tbl[k].rst;
      start = tbl[k].st;
      bus.src_vaild = tbl[k].v;
      bus.dst_ready = tbl[k].rdy;
      #2;
      check($sformatf("tbl%0d.srdy", k), 32'(bus.src_ready), 32'(tbl[k].e_srdy));
      check($sformatf("tbl%0d.dv", k), 32'(bus.dst_vaild), 32'(tbl[k].e_dv));
      check($sformatf("tbl%0d.id", k), 32'(bus.dst_id), 32'(tbl[k].e_id));
      check($sformatf("tbl%0d.last", k), 32'(bus.dst_last), 32'(tbl[k].e_last));
      if (tbl[k].e_dv) check($sformatf("tbl%0d.data", k), 32'(bus.dst_data), 32'(word(int'(tbl[k].e_id))));
      tick();
    end

    // Fairness: all sources busy, full bursts rotate 0,1,2,3,0 with one bubble each.
    do_reset();
    set_all_data();
    start = 1'b1;
    bus.src_vaild = '1;
    bus.dst_ready = 1'b1;
    for (int gi = 0; gi < 5; gi++) begin
      int g;
      g = gi % NUM_SRC;
      check_idle($sformatf("fair_gap%0d", gi));
      tick();
      for (int b = 0; b < BURST; b++) begin
        #2;
        check($sformatf("fair%0d_b%0d.id", gi, b), 32'(bus.dst_id), 32'(g));
        check($sformatf("fair%0d_b%0d.dv", gi, b), 32'(bus.dst_vaild), 32'd1);
        check($sformatf("fair%0d_b%0d.srdy", gi, b), 32'(bus.src_ready), 32'(1 << g));
        check($sformatf("fair%0d_b%0d.data", gi, b), 32'(bus.dst_data), 32'(word(g)));
        check($sformatf("fair%0d_b%0d.last", gi, b), 32'(bus.dst_last), 32'(b == BURST - 1));
        tick();
      end
    end

    // Backpressure: src1 alone, payload advances only on accepted beats.
    do_reset();
    start = 1'b1;
    bus.src_vaild = 4'b0010;
    begin
      int got;
      int cyc;
      logic rdy;
      got = 0;
      cyc = 0;
      bus.src_data[1*WIDTH +: WIDTH] = WIDTH'(9'h040);
      check_idle("bp_arb");
      tick();
      while (got < BURST && cyc < 64) begin
        rdy = (cyc % 2 == 0);
        bus.dst_ready = rdy;
        bus.src_data[1*WIDTH +: WIDTH] = WIDTH'(9'h040 + 9'(got));
        #2;
        check($sformatf("bp%0d.dv", cyc), 32'(bus.dst_vaild), 32'd1);
        check($sformatf("bp%0d.id", cyc), 32'(bus.dst_id), 32'd1);
        check($sformatf("bp%0d.data", cyc), 32'(bus.dst_data), 32'(9'h040 + 9'(got)));
        check($sformatf("bp%0d.last", cyc), 32'(bus.dst_last), 32'(got == BURST - 1));
        check($sformatf("bp%0d.srdy", cyc), 32'(bus.src_ready), rdy ? 32'h2 : 32'h0);
        tick();
        if (rdy) got++;
        cyc++;
      end
      check("bp_beats", 32'(got), 32'(BURST));
      check("bp_cycles", 32'(cyc), 32'(2 * BURST - 1));
      bus.dst_ready = 1'b1;
      check_idle("bp_release");
    end

    // Gating and wrap: start drops during src3's burst; next search starts at 0.
    do_reset();
    set_all_data();
    start = 1'b1;
    bus.src_vaild = 4'b1000;
    check_idle("gate_arb");
    tick();
    start = 1'b0;
    bus.src_vaild = 4'b1111;
    for (int b = 0; b < BURST; b++) begin
      #2;
      check($sformatf("gate_b%0d.id", b), 32'(bus.dst_id), 32'd3);
      check($sformatf("gate_b%0d.dv", b), 32'(bus.dst_vaild), 32'd1);
      check($sformatf("gate_b%0d.last", b), 32'(bus.dst_last), 32'(b == BURST - 1));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check_idle($sformatf("gate_hold%0d", i));
      tick();
    end
    start = 1'b1;
    check_idle("gate_rearb");
    tick();
    #2;
    check("gate_wrap.id", 32'(bus.dst_id), 32'd0);
    check("gate_wrap.srdy", 32'(bus.src_ready), 32'd1);
    tick();

    // Reset at beat 7 of src1: no handshake on the reset edge, src0 wins after.
    do_reset();
    set_all_data();
    start = 1'b1;
    bus.src_vaild = 4'b0010;
    check_idle("mrst_arb");
    tick();
    for (int b = 0; b < 7; b++) begin
      #2;
      check($sformatf("mrst_b%0d.srdy", b), 32'(bus.src_ready), 32'h2);
      tick();
    end
    s_rst = 1'b1;
    bus.src_vaild = 4'b0011;
    check_idle("mrst_edge");
    tick();
    s_rst = 1'b0;
    check_idle("mrst_idle");
    tick();
    #2;
    check("mrst_regrant.id", 32'(bus.dst_id), 32'd0);
    check("mrst_regrant.last", 32'(bus.dst_last), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
